// File: rtl/uart_cfg_sequencer.sv
// Purpose : master-side UART line-configuration handshake. Sends the four-packet
//           config sequence {data_width, stop_bits, parity, end} and waits for an
//           8'hFF ack after each byte; applies the config on success.
// Latency : start_i -> first tx_valid_o 2 cycles; DONE/FAIL is a 1-cycle state.
// Backpr. : tx_valid_o holds with tx_data_o stable until tx_ready_i; the ack
//           timer only runs while waiting for an ack, never while stalled.
// Ports   : clk_i/rst_n_i clock and async active-low reset; start_i + config_i
//           request a sequence; tx_data_o/tx_valid_o/tx_ready_i transmit path;
//           rx_data_i/rx_valid_i ack path; busy_o, config_o (applied config),
//           int_id_o (0110 done, 0001 fail, 0000 otherwise).
// Option  : define UART_CFG_RETRY_EN to resend a timed-out packet up to
//           MAX_RETRY times before failing; without it the first timeout fails.
module uart_cfg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [5:0] config_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       busy_o,
  output logic [5:0] config_o,
  output logic [3:0] int_id_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] SEND     = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] FAIL     = 3'd5;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  // 8-bit data, 2 stop bits, even parity
  localparam logic [5:0] CFG_RESET = 6'b11_11_01;

  localparam logic [3:0] INT_NONE = 4'b0000;
  localparam logic [3:0] INT_DONE = 4'b0110;
  localparam logic [3:0] INT_FAIL = 4'b0001;

  logic [2:0]    state;
  logic [5:0]    cfg_q;   // {data_width, stop_bits, parity_mode}
  logic [1:0]    index;
  logic [TW-1:0] timer;
  logic [7:0]    pkt;
  logic          ack;
  logic          timeout;
  logic          retry_ok;

  // An ack in the terminal-count cycle takes priority over the timeout.
  assign ack     = (state == WAIT_ACK) && rx_valid_i && (rx_data_i == 8'hFF);
  assign timeout = (state == WAIT_ACK) && !ack && (timer == TIMER_TERM);

`ifdef UART_CFG_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  logic [RW-1:0] retry;

  assign retry_ok = (retry < RETRY_LIMIT);

  // Counts resends of the current packet; cleared on every good ack and on
  // a new sequence, so each packet gets its own retry budget.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retry <= '0;
    end else if ((state == IDLE && start_i) || ack) begin
      retry <= '0;
    end else if (timeout && retry_ok) begin
      retry <= retry + 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    pkt = 8'h00;
    case (index)
      2'd0:    pkt = {4'b0000, cfg_q[5:4], 2'b01};
      2'd1:    pkt = {4'b0000, cfg_q[3:2], 2'b10};
      2'd2:    pkt = {4'b0000, cfg_q[1:0], 2'b11};
      default: pkt = 8'h00;
    endcase
  end

  // Outputs decode straight from the state register, so an asserted reset
  // forces them to their idle values without waiting for a clock edge.
  assign tx_valid_o = (state == SEND);
  assign tx_data_o  = (state == SEND) ? pkt : 8'h00;
  assign busy_o     = (state != IDLE);

  always_comb begin
    int_id_o = INT_NONE;
    if (state == DONE) int_id_o = INT_DONE;
    if (state == FAIL) int_id_o = INT_FAIL;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cfg_q    <= CFG_RESET;
      index    <= 2'd0;
      timer    <= '0;
      config_o <= CFG_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cfg_q <= config_i;
            state <= CHECK;
          end
        end
        CHECK: begin
          index <= 2'd0;
          // stop_bits 2'b10 is reserved: refuse before anything goes on the wire
          state <= (cfg_q[3:2] == 2'b10) ? FAIL : SEND;
        end
        SEND: begin
          if (tx_ready_i) begin
            timer <= '0;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            if (index == 2'd3) begin
              state <= DONE;
            end else begin
              index <= index + 2'd1;
              state <= SEND;
            end
          end else if (timeout) begin
            state <= retry_ok ? SEND : FAIL;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          config_o <= cfg_q;
          state    <= IDLE;
        end
        FAIL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
module tb_uart_cfg_sequencer;

  localparam int TO = 16;
  localparam int MR = 3;
`ifdef UART_CFG_RETRY_EN
  localparam int N_SENDS = MR + 1;
`else
  localparam int N_SENDS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] cfg_in = 6'd0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       busy;
  logic [5:0] cfg_out;
  logic [3:0] int_id;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] exp_tx[$];
  logic [3:0] exp_int[$];

  uart_cfg_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .config_i  (cfg_in),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .busy_o    (busy),
    .config_o  (cfg_out),
    .int_id_o  (int_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every accepted byte and every interrupt pulse is matched
  // against what the stimulus queued up.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      chk("tx_pending", 32'(exp_tx.size() > 0), 1);
      if (exp_tx.size() > 0) chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    if (rst_n && int_id != 4'd0) begin
      chk("int_pending", 32'(exp_int.size() > 0), 1);
      if (exp_int.size() > 0) chk("int_id", 32'(int_id), 32'(exp_int.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] c);
    cfg_in = c;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Counts falling edges until tx_valid or an interrupt is seen; optionally
  // strobes an rx byte on edge a1 (data d1) and edge a2 (data d2).
  task automatic wait_event(input int a1, input logic [7:0] d1,
                            input int a2, input logic [7:0] d2, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (tx_valid || int_id != 4'd0) begin
        seen = 1'b1;
        rx_valid = 1'b0;
      end else begin
        rx_valid = (n == a1) || (n == a2);
        rx_data  = (n == a2) ? d2 : d1;
      end
    end
    rx_valid = 1'b0;
    chk("event_seen", 32'(seen), 1);
  endtask

  task automatic end_seq();
    @(negedge clk);
    chk("int_one_cycle", 32'(int_id), 0);
    chk("idle_not_busy", 32'(busy), 0);
  endtask

  initial begin
    int n;
    int bad;

    // reset values
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_int", 32'(int_id), 0);
    chk("rst_cfg", 32'(cfg_out), 32'h3D);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reserved stop_bits: fail with nothing sent
    exp_int.push_back(4'b0001);
    do_start(6'b11_10_01);
    wait_event(-1, 8'h00, -1, 8'h00, n);
    chk("bad_stop_latency", n, 2);
    end_seq();
    chk("cfg_keep_bad_stop", 32'(cfg_out), 32'h3D);

    // full sequence, ack 5 cycles after each send
    exp_tx.push_back(8'h09); exp_tx.push_back(8'h02);
    exp_tx.push_back(8'h0F); exp_tx.push_back(8'h00);
    exp_int.push_back(4'b0110);
    do_start(6'b10_00_11);
    wait_event(-1, 8'h00, -1, 8'h00, n);
    chk("first_send_latency", n, 2);
    for (int i = 0; i < 4; i++) begin
      wait_event(5, 8'hFF, -1, 8'h00, n);
      chk("ack_advance", n, 6);
    end
    end_seq();
    chk("cfg_applied", 32'(cfg_out), 32'h23);

    // non-FF byte ignored, and it does not restart the timer
    exp_tx.push_back(8'h05);
    for (int i = 0; i < N_SENDS; i++) exp_tx.push_back(8'h06);
    exp_int.push_back(4'b0001);
    do_start(6'b01_01_00);
    wait_event(-1, 8'h00, -1, 8'h00, n);
    chk("first_send_latency2", n, 2);
    wait_event(3, 8'h55, 7, 8'hFF, n);
    chk("ack55_ignored", n, 8);
    wait_event(10, 8'h55, -1, 8'h00, n);
    chk("timer_not_reset", n, TO + 1);
    for (int r = 1; r < N_SENDS; r++) begin
      wait_event(-1, 8'h00, -1, 8'h00, n);
      chk("retry_gap", n, TO + 1);
    end
    end_seq();
    chk("cfg_keep_timeout", 32'(cfg_out), 32'h23);

    // transmitter stall for 10 cycles, then no ack at all
    tx_ready = 1'b0;
    for (int i = 0; i < N_SENDS; i++) exp_tx.push_back(8'h09);
    exp_int.push_back(4'b0001);
    do_start(6'b10_00_11);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h09) bad++;
      rx_valid = (i == 4);
      rx_data  = 8'hFF;
    end
    rx_valid = 1'b0;
    chk("stall_bad_cycles", bad, 0);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    @(negedge clk);
    wait_event(-1, 8'h00, -1, 8'h00, n);
    chk("timeout_after_stall", n, TO + 1);
    for (int r = 1; r < N_SENDS; r++) begin
      wait_event(-1, 8'h00, -1, 8'h00, n);
      chk("retry_gap2", n, TO + 1);
    end
    end_seq();

    // async reset during WAIT_ACK of index 2, then a clean restart
    exp_tx.push_back(8'h09); exp_tx.push_back(8'h02); exp_tx.push_back(8'h0F);
    do_start(6'b10_00_11);
    wait_event(-1, 8'h00, -1, 8'h00, n);
    wait_event(5, 8'hFF, -1, 8'h00, n);
    wait_event(5, 8'hFF, -1, 8'h00, n);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_int", 32'(int_id), 0);
    chk("midrst_cfg", 32'(cfg_out), 32'h3D);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_tx.push_back(8'h09); exp_tx.push_back(8'h02);
    exp_tx.push_back(8'h0F); exp_tx.push_back(8'h00);
    exp_int.push_back(4'b0110);
    do_start(6'b10_00_11);
    wait_event(-1, 8'h00, -1, 8'h00, n);
    chk("restart_latency", n, 2);
    for (int i = 0; i < 4; i++) begin
      wait_event(5, 8'hFF, -1, 8'h00, n);
      chk("restart_ack_advance", n, 6);
    end
    end_seq();
    chk("cfg_after_restart", 32'(cfg_out), 32'h23);

    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("int_queue_drained", exp_int.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
